// File: rtl/ft_uart_pattern_trigger.sv
// rtl/ft_uart_pattern_trigger.sv - multi-pattern byte-stream matcher snooping the UART TX FIFO write port
module ft_uart_pattern_trigger #(
    parameter int DATA_W  = 8,
    parameter int NUM_PAT = 3,
    parameter int PAT_LEN = 4,
    parameter int LEN_W   = 3,
    parameter int HIT_W   = 8,
    // Byte 0 of each pattern sits in the low bits, so the strings read reversed:
    // pattern 0 = "ABCD", pattern 1 = "EFGH", pattern 2 = "proc".
    parameter logic [NUM_PAT*PAT_LEN*DATA_W-1:0] DEF_PATS = {"corp", "HGFE", "DCBA"}
) (
    input  logic                                      clock,
    input  logic                                      reset_n,
    input  logic [DATA_W-1:0]                         tx_payload,
    input  logic                                      tx_valid,
    input  logic                                      cfg_we,
    input  logic [((NUM_PAT > 1) ? $clog2(NUM_PAT) : 1)-1:0] cfg_pat,
    input  logic [((PAT_LEN > 1) ? $clog2(PAT_LEN) : 1)-1:0] cfg_pos,
    input  logic [DATA_W-1:0]                         cfg_data,
    input  logic                                      len_we,
    input  logic [LEN_W-1:0]                          len_data,
    input  logic                                      clear,
    output logic [NUM_PAT-1:0]                        match_pulse,
    output logic [NUM_PAT-1:0]                        match_sticky,
    output logic [NUM_PAT*HIT_W-1:0]                  hit_count
);

    localparam int CNT_W = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;

    logic [DATA_W-1:0]  patMem [NUM_PAT][PAT_LEN];
    logic [LEN_W-1:0]   lenMem [NUM_PAT];
    logic [CNT_W-1:0]   cnt    [NUM_PAT];
    logic [CNT_W-1:0]   cntNext[NUM_PAT];
    logic [HIT_W-1:0]   hitCnt [NUM_PAT];
    logic [NUM_PAT-1:0] hitNow;
    logic [NUM_PAT-1:0] pulseReg;
    logic [NUM_PAT-1:0] stickyReg;

    logic [31:0] cfgPatExt;
    logic [31:0] cfgPosExt;
    logic        cfgPatOk;
    logic        patWrite;
    logic        lenWrite;

    assign cfgPatExt = 32'(cfg_pat);
    assign cfgPosExt = 32'(cfg_pos);
    assign cfgPatOk  = cfgPatExt < NUM_PAT;
    assign patWrite  = cfg_we && cfgPatOk && (cfgPosExt < PAT_LEN);
    assign lenWrite  = len_we && cfgPatOk;

    // Per-pattern progress update; a config write to a pattern resets it and kills any match that edge.
    always_comb begin
        hitNow = '0;
        for (int p = 0; p < NUM_PAT; p++) begin
            cntNext[p] = cnt[p];
        end
        for (int p = 0; p < NUM_PAT; p++) begin
            if ((lenMem[p] == '0) || (32'(lenMem[p]) > PAT_LEN)) begin
                cntNext[p] = '0;
            end else if (tx_valid) begin
                if (tx_payload == patMem[p][cnt[p]]) begin
                    if (32'(cnt[p]) + 32'd1 == 32'(lenMem[p])) begin
                        hitNow[p]  = 1'b1;
                        cntNext[p] = '0;
                    end else begin
                        cntNext[p] = cnt[p] + 1'b1;
                    end
                end else if (tx_payload == patMem[p][0]) begin
                    // Mismatch on a byte that starts the pattern: restart at position 1, no deeper overlap search.
                    if (lenMem[p] == LEN_W'(1)) begin
                        hitNow[p]  = 1'b1;
                        cntNext[p] = '0;
                    end else begin
                        cntNext[p] = CNT_W'(1);
                    end
                end else begin
                    cntNext[p] = '0;
                end
            end
            if ((patWrite || lenWrite) && (cfgPatExt == p)) begin
                cntNext[p] = '0;
                hitNow[p]  = 1'b0;
            end
        end
    end

    // Pattern and length storage, reloaded from defaults on reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int p = 0; p < NUM_PAT; p++) begin
                for (int k = 0; k < PAT_LEN; k++) begin
                    patMem[p][k] <= DEF_PATS[(p*PAT_LEN+k)*DATA_W +: DATA_W];
                end
                lenMem[p] <= LEN_W'(PAT_LEN);
            end
        end else begin
            if (patWrite) begin
                patMem[cfg_pat][cfg_pos] <= cfg_data;
            end
            if (lenWrite) begin
                lenMem[cfg_pat] <= len_data;
            end
        end
    end

    // Match state: progress counters, pulse, sticky flags (set beats clear) and saturating hit counters.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pulseReg  <= '0;
            stickyReg <= '0;
            for (int p = 0; p < NUM_PAT; p++) begin
                cnt[p]    <= '0;
                hitCnt[p] <= '0;
            end
        end else begin
            pulseReg <= hitNow;
            for (int p = 0; p < NUM_PAT; p++) begin
                cnt[p] <= cntNext[p];
                if (hitNow[p]) begin
                    stickyReg[p] <= 1'b1;
                end else if (clear) begin
                    stickyReg[p] <= 1'b0;
                end
                if (hitNow[p] && (hitCnt[p] != {HIT_W{1'b1}})) begin
                    hitCnt[p] <= hitCnt[p] + 1'b1;
                end
            end
        end
    end

    assign match_pulse  = pulseReg;
    assign match_sticky = stickyReg;

    // Flatten the per-pattern counters onto the output bus.
    always_comb begin
        hit_count = '0;
        for (int p = 0; p < NUM_PAT; p++) begin
            hit_count[p*HIT_W +: HIT_W] = hitCnt[p];
        end
    end

endmodule

// File: tb/tb_ft_uart_pattern_trigger.sv
// tb/tb_ft_uart_pattern_trigger.sv - directed table-driven bench for ft_uart_pattern_trigger
module tb_ft_uart_pattern_trigger;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [7:0]  tx_payload;
    logic        tx_valid;
    logic        cfg_we;
    logic [1:0]  cfg_pat;
    logic [1:0]  cfg_pos;
    logic [7:0]  cfg_data;
    logic        len_we;
    logic [2:0]  len_data;
    logic        clear;
    logic [2:0]  match_pulse;
    logic [2:0]  match_sticky;
    logic [23:0] hit_count;
    logic [2:0]  pulseSat;
    logic [2:0]  stickySat;
    logic [5:0]  hitSat;

    int nChecks = 0;
    int nErrors = 0;

    always #5 clock = ~clock;

    ft_uart_pattern_trigger dut (
        .clock(clock), .reset_n(reset_n), .tx_payload(tx_payload), .tx_valid(tx_valid),
        .cfg_we(cfg_we), .cfg_pat(cfg_pat), .cfg_pos(cfg_pos), .cfg_data(cfg_data),
        .len_we(len_we), .len_data(len_data), .clear(clear),
        .match_pulse(match_pulse), .match_sticky(match_sticky), .hit_count(hit_count)
    );

    ft_uart_pattern_trigger #(.HIT_W(2)) dutSat (
        .clock(clock), .reset_n(reset_n), .tx_payload(tx_payload), .tx_valid(tx_valid),
        .cfg_we(cfg_we), .cfg_pat(cfg_pat), .cfg_pos(cfg_pos), .cfg_data(cfg_data),
        .len_we(len_we), .len_data(len_data), .clear(clear),
        .match_pulse(pulseSat), .match_sticky(stickySat), .hit_count(hitSat)
    );

    typedef struct {
        logic        v;
        logic [7:0]  b;
        logic        clr;
        logic [2:0]  pulse;
        logic [2:0]  sticky;
        logic [23:0] hit;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic sendByte(input logic [7:0] b);
        tx_valid   = 1'b1;
        tx_payload = b;
        tick();
        tx_valid   = 1'b0;
    endtask

    task automatic addV(input logic v, input logic [7:0] b, input logic clr, input logic [2:0] pulse,
                        input logic [2:0] sticky, input logic [7:0] h0, input logic [7:0] h1,
                        input logic [7:0] h2);
        vec_t t;
        t.v = v; t.b = b; t.clr = clr; t.pulse = pulse; t.sticky = sticky; t.hit = {h2, h1, h0};
        vecs.push_back(t);
    endtask

    task automatic addBytes(input string s, input logic [2:0] sticky, input logic [7:0] h0,
                            input logic [7:0] h1, input logic [7:0] h2);
        for (int i = 0; i < s.len(); i++) addV(1'b1, s[i], 1'b0, 3'b000, sticky, h0, h1, h2);
    endtask

    initial begin
        logic [2:0] seenP2;

        reset_n = 1'b0; tx_payload = '0; tx_valid = 1'b0; cfg_we = 1'b0; cfg_pat = '0;
        cfg_pos = '0; cfg_data = '0; len_we = 1'b0; len_data = '0; clear = 1'b0;

        // Row expectations: outputs seen the cycle after the row's edge.
        addBytes("ABC", 3'b000, 0, 0, 0);
        addV(1, "D", 0, 3'b001, 3'b001, 1, 0, 0);
        addV(0, 0,   0, 3'b000, 3'b001, 1, 0, 0);
        addBytes("ABABC", 3'b001, 1, 0, 0);
        addV(1, "D", 0, 3'b001, 3'b001, 2, 0, 0);
        addBytes("AABC", 3'b001, 2, 0, 0);
        addV(1, "D", 0, 3'b001, 3'b001, 3, 0, 0);
        addBytes("EFEGH", 3'b001, 3, 0, 0);
        addV(1, "A", 0, 3'b000, 3'b001, 3, 0, 0);
        addV(0, 0,   0, 3'b000, 3'b001, 3, 0, 0);
        addV(1, "B", 0, 3'b000, 3'b001, 3, 0, 0);
        addV(0, 0,   0, 3'b000, 3'b001, 3, 0, 0);
        addV(0, 0,   0, 3'b000, 3'b001, 3, 0, 0);
        addV(1, "C", 0, 3'b000, 3'b001, 3, 0, 0);
        addV(0, 0,   0, 3'b000, 3'b001, 3, 0, 0);
        addV(1, "D", 0, 3'b001, 3'b001, 4, 0, 0);
        addV(0, 0,   0, 3'b000, 3'b001, 4, 0, 0);
        addBytes("ABC", 3'b001, 4, 0, 0);
        addV(1, "D", 0, 3'b001, 3'b001, 5, 0, 0);
        addBytes("ABC", 3'b001, 5, 0, 0);
        addV(1, "D", 0, 3'b001, 3'b001, 6, 0, 0);
        addBytes("EFG", 3'b001, 6, 0, 0);
        addV(1, "H", 0, 3'b010, 3'b011, 6, 1, 0);
        addBytes("pro", 3'b011, 6, 1, 0);
        addV(1, "c", 0, 3'b100, 3'b111, 6, 1, 1);
        addV(0, 0,   1, 3'b000, 3'b000, 6, 1, 1);
        addBytes("ABC", 3'b000, 6, 1, 1);
        addV(1, "D", 1, 3'b001, 3'b001, 7, 1, 1);
        addV(0, 0,   0, 3'b000, 3'b001, 7, 1, 1);

        tick(); tick();
        check("reset_pulse", match_pulse, 0);
        check("reset_sticky", match_sticky, 0);
        check("reset_hit", hit_count, 0);
        check("reset_hit_sat", hitSat, 0);
        reset_n = 1'b1;
        tick();

        foreach (vecs[i]) begin
            tx_valid = vecs[i].v; tx_payload = vecs[i].b; clear = vecs[i].clr;
            tick();
            tx_valid = 1'b0; clear = 1'b0;
            check($sformatf("vec%0d_pulse", i), match_pulse, vecs[i].pulse);
            check($sformatf("vec%0d_sticky", i), match_sticky, vecs[i].sticky);
            check($sformatf("vec%0d_hit", i), hit_count, vecs[i].hit);
        end

        // Reprogram pattern 2 as "ok" (length 2).
        cfg_pat = 2; len_we = 1; len_data = 2; tick(); len_we = 0;
        cfg_we = 1; cfg_pos = 0; cfg_data = "o"; tick();
        cfg_pos = 1; cfg_data = "k"; tick(); cfg_we = 0;
        sendByte("o"); check("ok_first", match_pulse, 3'b000);
        sendByte("k"); check("ok_pulse", match_pulse, 3'b100);
        check("ok_hit", hit_count[23:16], 2);
        seenP2 = '0;
        sendByte("p"); seenP2 |= match_pulse;
        sendByte("r"); seenP2 |= match_pulse;
        sendByte("o"); seenP2 |= match_pulse;
        sendByte("c"); seenP2 |= match_pulse;
        check("proc_no_p2", seenP2[2], 0);
        len_we = 1; len_data = 0; tick(); len_we = 0;
        sendByte("o"); sendByte("k");
        check("len0_pulse", match_pulse, 0);
        len_we = 1; len_data = 5; tick(); len_we = 0;
        sendByte("o"); sendByte("k");
        check("len5_pulse", match_pulse, 0);
        check("len_dis_hit", hit_count[23:16], 2);
        len_we = 1; len_data = 2; tick(); len_we = 0;
        sendByte("o"); sendByte("k");
        check("len2_again", match_pulse, 3'b100);

        // Config write to pattern 0 on the edge of its final byte suppresses the match and zeroes cnt.
        sendByte("A"); sendByte("B"); sendByte("C");
        tx_valid = 1; tx_payload = "D"; cfg_we = 1; cfg_pat = 0; cfg_pos = 3; cfg_data = "D";
        tick();
        tx_valid = 0; cfg_we = 0;
        check("cfgsup_pulse", match_pulse, 0);
        check("cfgsup_hit", hit_count[7:0], 7);
        sendByte("D"); check("cfgsup_cnt0", match_pulse, 0);
        sendByte("A"); sendByte("B"); sendByte("C"); sendByte("D");
        check("cfgsup_after", match_pulse, 3'b001);
        check("cfgsup_after_hit", hit_count[7:0], 8);

        // Reset in the middle of a pattern.
        sendByte("A"); sendByte("B");
        reset_n = 0; tick();
        check("midrst_pulse", match_pulse, 0);
        check("midrst_sticky", match_sticky, 0);
        check("midrst_hit", hit_count, 0);
        reset_n = 1;
        sendByte("C"); sendByte("D");
        check("midrst_cd", match_pulse, 0);
        sendByte("p"); sendByte("r"); sendByte("o"); sendByte("c");
        check("rst_restores_p2", match_pulse, 3'b100);

        // Five back-to-back matches: 2-bit counter saturates, pulse keeps firing.
        for (int n = 0; n < 5; n++) begin
            sendByte("A"); sendByte("B"); sendByte("C"); sendByte("D");
            check($sformatf("sat%0d_pulse", n), pulseSat[0], 1);
            check($sformatf("sat%0d_pulse_main", n), match_pulse[0], 1);
        end
        check("sat_hit", hitSat[1:0], 3);
        check("sat_hit_main", hit_count[7:0], 5);
        check("sat_sticky", stickySat[0], 1);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
